// File: rtl/t5_pkg.sv
// Shared constants for the t5 Wishbone arbiter: grant FSM encoding and the
// full-word byte select driven for instruction fetches.
package t5_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IGNT = 2'd1;
  localparam logic [1:0] DGNT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/t5_wb_arb.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with registered
// grant, registered response and a bounded data-priority starvation guard.
module t5_wb_arb
  import t5_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DSTARVE = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [29:0]     iwb_adr,
  input  logic            iwb_stb,
  input  logic            iwb_wre,
  input  logic [3:0]      iwb_sel,
  output logic [31:0]     iwb_dat,
  output logic            iwb_ack,
  input  logic [29:0]     dwb_adr,
  input  logic            dwb_stb,
  input  logic            dwb_wre,
  input  logic [3:0]      dwb_sel,
  input  logic [XLEN-1:0] dwb_dto,
  output logic [XLEN-1:0] dwb_dti,
  output logic            dwb_ack,
  output logic [29:0]     mwb_adr,
  output logic            mwb_stb,
  output logic            mwb_wre,
  output logic [3:0]      mwb_sel,
  output logic [XLEN-1:0] mwb_dto,
  input  logic [XLEN-1:0] mwb_dti,
  input  logic            mwb_ack
);

  localparam int            CW   = $clog2(DSTARVE + 2);
  localparam logic [CW-1:0] CMAX = CW'(DSTARVE);

  logic [1:0]      r_state;
  logic [29:0]     r_adr;
  logic            r_stb;
  logic            r_wre;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_dto;
  logic [31:0]     r_idat;
  logic [XLEN-1:0] r_ddat;
  logic            r_iack;
  logic            r_dack;
  logic            r_drop;
  logic [CW-1:0]   r_cnt;

  logic w_starved;
  logic w_pick_d;
  logic w_gstb;
  logic w_valid;
  logic w_unused;

  // Instruction port is read-only; its write enable and byte select carry no information.
  assign w_unused = ^{iwb_wre, iwb_sel};

  assign w_starved = (DSTARVE != 0) && (r_cnt == CMAX);
  assign w_pick_d  = dwb_stb && !(iwb_stb && w_starved);
  assign w_gstb    = (r_state == IGNT) ? iwb_stb : dwb_stb;
  // A master that let go of stb at any point during its grant gets no ack or data.
  assign w_valid   = w_gstb && !r_drop;

  // NOTE: every flop, including the data registers, takes the async reset so all
  // outputs are defined the moment rst drops; updates use <= so each register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_stb   <= 1'b0;
      r_wre   <= 1'b0;
      r_sel   <= '0;
      r_dto   <= '0;
      r_idat  <= '0;
      r_ddat  <= '0;
      r_iack  <= 1'b0;
      r_dack  <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_iack <= 1'b0;
      r_dack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= DGNT;
            r_stb   <= 1'b1;
            r_adr   <= dwb_adr;
            r_sel   <= dwb_sel;
            r_wre   <= dwb_wre;
            r_dto   <= dwb_dto;
            r_drop  <= 1'b0;
          end else if (iwb_stb) begin
            r_state <= IGNT;
            r_stb   <= 1'b1;
            r_adr   <= iwb_adr;
            r_sel   <= SEL_WORD;
            r_wre   <= 1'b0;
            r_dto   <= '0;
            r_drop  <= 1'b0;
          end
          if (!iwb_stb) begin
            r_cnt <= '0;
          end else if (w_pick_d) begin
            if (r_cnt != CMAX) r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        IGNT, DGNT: begin
          if (!w_gstb) r_drop <= 1'b1;
          if (mwb_ack) begin
            r_stb   <= 1'b0;
            r_state <= RESP;
            if (w_valid) begin
              if (r_state == IGNT) begin
                r_iack <= 1'b1;
                r_idat <= mwb_dti[31:0];
              end else begin
                r_dack <= 1'b1;
                r_ddat <= mwb_dti;
              end
            end
          end
        end
        RESP: r_state <= IDLE;
      endcase
    end
  end

  assign mwb_adr = r_adr;
  assign mwb_stb = r_stb;
  assign mwb_wre = r_wre;
  assign mwb_sel = r_sel;
  assign mwb_dto = r_dto;
  assign iwb_dat = r_idat;
  assign iwb_ack = r_iack;
  assign dwb_dti = r_ddat;
  assign dwb_ack = r_dack;

endmodule

// File: tb/tb_t5_wb_arb.sv
// Directed bench for t5_wb_arb: fetch, waited write, read, abandon, async reset,
// starvation guard (DSTARVE=4) and data-always-wins (DSTARVE=0).
module tb_t5_wb_arb;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [29:0] iwb_adr;
  logic        iwb_stb, iwb_wre;
  logic [3:0]  iwb_sel;
  logic [29:0] dwb_adr;
  logic        dwb_stb, dwb_wre;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dto, mwb_dti;
  logic        mwb_ack;

  logic [31:0] iwb_dat, dwb_dti, mwb_dto;
  logic        iwb_ack, dwb_ack, mwb_stb, mwb_wre;
  logic [29:0] mwb_adr;
  logic [3:0]  mwb_sel;

  logic [31:0] z_idat, z_ddti, z_mdto;
  logic        z_iack, z_dack, z_mstb, z_mwre;
  logic [29:0] z_madr;
  logic [3:0]  z_msel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  t5_wb_arb #(.XLEN(32), .DSTARVE(4)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
    .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dwb_adr(dwb_adr), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel),
    .dwb_dto(dwb_dto), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mwb_adr(mwb_adr), .mwb_stb(mwb_stb), .mwb_wre(mwb_wre), .mwb_sel(mwb_sel),
    .mwb_dto(mwb_dto), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack)
  );

  t5_wb_arb #(.XLEN(32), .DSTARVE(0)) dut_s0 (
    .sys_clk(clk), .sys_rst(sys_rst),
    .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
    .iwb_dat(z_idat), .iwb_ack(z_iack),
    .dwb_adr(dwb_adr), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_sel(dwb_sel),
    .dwb_dto(dwb_dto), .dwb_dti(z_ddti), .dwb_ack(z_dack),
    .mwb_adr(z_madr), .mwb_stb(z_mstb), .mwb_wre(z_mwre), .mwb_sel(z_msel),
    .mwb_dto(z_mdto), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after an edge with the arbiter in IDLE; this is cycle 0.
  task automatic fetch(input logic [29:0] adr, input logic [31:0] dat, input string tag);
    iwb_stb = 1'b1;
    iwb_adr = adr;
    tick();
    check({tag, ".c1.stb"}, mwb_stb, 1);
    check({tag, ".c1.adr"}, mwb_adr, adr);
    check({tag, ".c1.sel"}, mwb_sel, 4'hF);
    check({tag, ".c1.wre"}, mwb_wre, 0);
    check({tag, ".c1.iack"}, iwb_ack, 0);
    mwb_ack = 1'b1;
    mwb_dti = dat;
    tick();
    check({tag, ".c2.iack"}, iwb_ack, 1);
    check({tag, ".c2.idat"}, iwb_dat, dat);
    check({tag, ".c2.dack"}, dwb_ack, 0);
    check({tag, ".c2.stb"}, mwb_stb, 0);
    mwb_ack = 1'b0;
    iwb_stb = 1'b0;
    tick();
    check({tag, ".c3.iack"}, iwb_ack, 0);
  endtask

  logic got_i [6];
  logic exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    sys_rst = 1'b0;
    iwb_adr = '0; iwb_stb = 1'b0; iwb_wre = 1'b0; iwb_sel = 4'h0;
    dwb_adr = '0; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_sel = 4'h0;
    dwb_dto = '0; mwb_dti = '0;   mwb_ack = 1'b0;

    #12;
    check("rst.stb", mwb_stb, 0);
    check("rst.iack", iwb_ack, 0);
    check("rst.dack", dwb_ack, 0);
    check("rst.adr", mwb_adr, 0);
    sys_rst = 1'b1;
    tick();

    fetch(30'h40, 32'h0000_0013, "fetch");

    // Byte write with three wait states; live dto changes mid-cycle but the bus must not.
    dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_sel = 4'h2;
    dwb_adr = 30'h800; dwb_dto = 32'h0000_AB00;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("wr.c%0d.stb", c), mwb_stb, 1);
      check($sformatf("wr.c%0d.adr", c), mwb_adr, 30'h800);
      check($sformatf("wr.c%0d.sel", c), mwb_sel, 4'h2);
      check($sformatf("wr.c%0d.wre", c), mwb_wre, 1);
      check($sformatf("wr.c%0d.dto", c), mwb_dto, 32'h0000_AB00);
      check($sformatf("wr.c%0d.dack", c), dwb_ack, 0);
      if (c == 2) dwb_dto = 32'hFFFF_FFFF;
      if (c == 4) begin mwb_ack = 1'b1; mwb_dti = 32'h0000_5555; end
    end
    tick();
    check("wr.c5.dack", dwb_ack, 1);
    check("wr.c5.stb", mwb_stb, 0);
    check("wr.c5.iack", iwb_ack, 0);
    mwb_ack = 1'b0; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_dto = '0;
    tick();
    check("wr.c6.dack", dwb_ack, 0);

    dwb_stb = 1'b1; dwb_adr = 30'h300; dwb_sel = 4'hF;
    tick();
    check("rd.c1.adr", mwb_adr, 30'h300);
    check("rd.c1.wre", mwb_wre, 0);
    mwb_ack = 1'b1; mwb_dti = 32'hCAFE_F00D;
    tick();
    check("rd.c2.dack", dwb_ack, 1);
    check("rd.c2.dti", dwb_dti, 32'hCAFE_F00D);
    mwb_ack = 1'b0; dwb_stb = 1'b0;
    tick();

    // Abandon: master drops stb at cycle 2, slave acks at cycle 4.
    dwb_stb = 1'b1; dwb_adr = 30'h301;
    tick();
    check("ab.c1.stb", mwb_stb, 1);
    tick();
    check("ab.c2.stb", mwb_stb, 1);
    dwb_stb = 1'b0; mwb_dti = 32'h1234_5678;
    tick();
    check("ab.c3.stb", mwb_stb, 1);
    tick();
    check("ab.c4.stb", mwb_stb, 1);
    mwb_ack = 1'b1;
    tick();
    check("ab.c5.stb", mwb_stb, 0);
    check("ab.c5.dack", dwb_ack, 0);
    check("ab.c5.dti", dwb_dti, 32'hCAFE_F00D);
    mwb_ack = 1'b0;
    tick();
    check("ab.c6.dack", dwb_ack, 0);
    fetch(30'h44, 32'h0010_0093, "refetch");

    // Asynchronous reset while a data grant is on the bus.
    dwb_stb = 1'b1; dwb_adr = 30'h400; dwb_wre = 1'b1; dwb_sel = 4'hF; dwb_dto = 32'h0000_DEAD;
    tick();
    check("mr.c1.stb", mwb_stb, 1);
    #2 sys_rst = 1'b0;
    #1;
    check("mr.stb", mwb_stb, 0);
    check("mr.wre", mwb_wre, 0);
    check("mr.adr", mwb_adr, 0);
    check("mr.sel", mwb_sel, 0);
    check("mr.dto", mwb_dto, 0);
    check("mr.iack", iwb_ack, 0);
    check("mr.dack", dwb_ack, 0);
    check("mr.idat", iwb_dat, 0);
    check("mr.dti", dwb_dti, 0);
    dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_dto = '0;
    @(negedge clk);
    sys_rst = 1'b1;
    tick();
    fetch(30'h48, 32'h0000_0073, "postrst");

    // Both masters request continuously with a zero-wait slave.
    iwb_adr = 30'h10; dwb_adr = 30'h20; dwb_wre = 1'b0; dwb_sel = 4'hF;
    iwb_stb = 1'b1; dwb_stb = 1'b1; mwb_ack = 1'b1; mwb_dti = 32'h0000_0077;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 24 && n < 6; c++) begin
        tick();
        if (iwb_ack || dwb_ack) begin
          check($sformatf("sim.both%0d", n), iwb_ack & dwb_ack, 0);
          check($sformatf("sim.cyc%0d", n), c, 3 * n + 1);
          check($sformatf("s0.dack%0d", n), z_dack, 1);
          check($sformatf("s0.iack%0d", n), z_iack, 0);
          got_i[n] = iwb_ack;
          n++;
        end
      end
      check("sim.count", n, 6);
      for (int i = 0; i < 6; i++)
        if (i < n) check($sformatf("sim.g%0d", i), got_i[i], exp_i[i]);
    end

    // Data drops during RESP; the next arbitration must go to the instruction port.
    dwb_stb = 1'b0;
    tick();
    tick();
    tick();
    check("s0.i.iack", z_iack, 1);
    check("s0.i.dack", z_dack, 0);
    check("s0.i.idat", z_idat, 32'h0000_0077);
    iwb_stb = 1'b0; mwb_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
